// File: rtl/alpharetz_spi_pkg.sv
`default_nettype none
// ============================================================================
// alpharetz_spi_pkg: shared SPI constants and transfer FSM state encoding
// Rev 1.0
// ============================================================================
package alpharetz_spi_pkg;

  localparam int CLOCK_RATIO        = 4;
  localparam int DEFAULT_DATA_WIDTH = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_XFER  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_DONE  = 3'd4
  } xfer_state_t;

endpackage
`default_nettype wire

// File: rtl/spi_xfer_ctrl_if.sv
`default_nettype none
// ============================================================================
// spi_xfer_ctrl_if: request/response handshake plus SPI pins of one transfer
// Rev 1.0
// ============================================================================
interface spi_xfer_ctrl_if #(
  parameter int DATA_WIDTH = alpharetz_spi_pkg::DEFAULT_DATA_WIDTH
);

  logic                  start;
  logic                  cpol;
  logic                  cpha;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  busy;
  logic                  done;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  sclk;
  logic                  mosi;
  logic                  miso;
  logic                  cs_n;

  modport master (
    output start, cpol, cpha, tx_data, miso,
    input  busy, done, rx_data, sclk, mosi, cs_n
  );

  modport slave (
    input  start, cpol, cpha, tx_data, miso,
    output busy, done, rx_data, sclk, mosi, cs_n
  );

endinterface
`default_nettype wire

// File: rtl/spi_half_tick.sv
`default_nettype none
// ============================================================================
// spi_half_tick: half-SCLK-period timer, counts 0..HALF-1 and ticks on the last
// Rev 1.0
// ============================================================================
module spi_half_tick #(
  parameter int HALF = 2
) (
  input  logic clk_in,
  input  logic async_rst,
  input  logic i_clear,
  output logic o_tick
);

  localparam int               CNT_W  = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(HALF - 1);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk_in or posedge async_rst) begin
    if (async_rst) begin
      r_count <= '0;
    end else if (i_clear || o_tick) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_tick = (r_count == C_LAST);

endmodule
`default_nettype wire

// File: rtl/spi_xfer_ctrl.sv
`default_nettype none
// ============================================================================
// spi_xfer_ctrl: single-word SPI master (modes 0-3), MSB first, one done pulse
// Rev 1.0
// ============================================================================
module spi_xfer_ctrl #(
  parameter int DATA_WIDTH  = alpharetz_spi_pkg::DEFAULT_DATA_WIDTH,
  parameter int CLOCK_RATIO = alpharetz_spi_pkg::CLOCK_RATIO
) (
  input  logic            clk_in,
  input  logic            async_rst,
  spi_xfer_ctrl_if.slave  bus
);

  import alpharetz_spi_pkg::*;

  localparam int                HALF        = CLOCK_RATIO / 2;
  localparam int                EDGES       = 2 * DATA_WIDTH;
  localparam int                EDGE_W      = $clog2(EDGES + 1);
  localparam logic [EDGE_W-1:0] C_LAST_PREV = EDGE_W'(EDGES - 1);

  xfer_state_t           r_state;
  xfer_state_t           w_next;
  logic                  w_tick;
  logic                  w_clear;
  logic                  r_cpol;
  logic                  r_cpha;
  logic [DATA_WIDTH-1:0] r_tx;
  logic [DATA_WIDTH-1:0] r_rx;
  logic [DATA_WIDTH-1:0] r_rx_data;
  logic [EDGE_W-1:0]     r_edge_cnt;
  logic                  r_sclk;
  logic                  r_mosi;
  logic                  r_cs_n;
  logic                  w_edge;
  logic                  w_leading;
  logic                  w_last_edge;
  logic                  w_shift;
  logic                  w_sample;

  // Timer restarts on every state change so each phase starts a full half period.
  assign w_clear = (r_state == ST_IDLE) || (w_next != r_state);

  spi_half_tick #(
    .HALF (HALF)
  ) u_half_tick (
    .clk_in    (clk_in),
    .async_rst (async_rst),
    .i_clear   (w_clear),
    .o_tick    (w_tick)
  );

  // Edge about to happen is number r_edge_cnt+1; odd numbers are leading edges.
  assign w_edge      = (r_state == ST_XFER) && w_tick;
  assign w_leading   = ~r_edge_cnt[0];
  assign w_last_edge = (r_edge_cnt == C_LAST_PREV);
  assign w_sample    = w_edge && (r_cpha ? ~w_leading : w_leading);
  assign w_shift     = w_edge && (r_cpha ? w_leading : (~w_leading && !w_last_edge));

  always_ff @(posedge clk_in or posedge async_rst) begin
    if (async_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (bus.start)                w_next = ST_SETUP;
      ST_SETUP: if (w_tick)                   w_next = ST_XFER;
      ST_XFER:  if (w_edge && w_last_edge)    w_next = ST_HOLD;
      ST_HOLD:  if (w_tick)                   w_next = ST_DONE;
      ST_DONE:                                w_next = ST_IDLE;
      default:                                w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge async_rst) begin
    if (async_rst) begin
      r_cpol     <= 1'b0;
      r_cpha     <= 1'b0;
      r_tx       <= '0;
      r_rx       <= '0;
      r_rx_data  <= '0;
      r_edge_cnt <= '0;
      r_sclk     <= 1'b0;
      r_mosi     <= 1'b0;
      r_cs_n     <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_sclk     <= bus.cpol;
          r_edge_cnt <= '0;
          if (bus.start) begin
            r_cpol <= bus.cpol;
            r_cpha <= bus.cpha;
            r_cs_n <= 1'b0;
            r_rx   <= '0;
            // Mode cpha=0 presents the MSB now; cpha=1 waits for the first leading edge.
            if (bus.cpha) begin
              r_tx <= bus.tx_data;
            end else begin
              r_tx   <= bus.tx_data << 1;
              r_mosi <= bus.tx_data[DATA_WIDTH-1];
            end
          end
        end
        ST_XFER: begin
          if (w_edge) begin
            r_sclk     <= ~r_sclk;
            r_edge_cnt <= r_edge_cnt + EDGE_W'(1);
          end
          if (w_shift) begin
            r_mosi <= r_tx[DATA_WIDTH-1];
            r_tx   <= r_tx << 1;
          end
          if (w_sample) begin
            r_rx <= {r_rx[DATA_WIDTH-2:0], bus.miso};
          end
        end
        ST_HOLD: begin
          r_sclk <= r_cpol;
          if (w_tick) begin
            r_cs_n    <= 1'b1;
            r_rx_data <= r_rx;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    bus.busy    = (r_state != ST_IDLE);
    bus.done    = (r_state == ST_DONE);
    bus.rx_data = r_rx_data;
    bus.sclk    = r_sclk;
    bus.mosi    = r_mosi;
    bus.cs_n    = r_cs_n;
  end

endmodule
`default_nettype wire

// File: tb/tb_spi_xfer_ctrl.sv
`default_nettype none
// ============================================================================
// tb_spi_xfer_ctrl: table-driven transfers in all modes plus restart/abort sequences
// Rev 1.0
// ============================================================================
module tb_spi_xfer_ctrl;

  localparam int W        = 8;
  localparam int RATIO    = 4;
  localparam int HALF     = RATIO / 2;
  localparam int DONE_CYC = (2 * W + 2) * HALF + 1;
  localparam int CS_LOW   = (2 * W + 2) * HALF;

  typedef struct {
    logic         cpol;
    logic         cpha;
    logic [W-1:0] tx;
    logic [W-1:0] miso_word;
    logic         loopback;
    logic [W-1:0] exp_rx;
  } vec_t;

  logic clk_in    = 1'b0;
  logic async_rst = 1'b0;
  logic loopback  = 1'b0;
  logic miso_bit  = 1'b0;

  int n_pass  = 0;
  int n_total = 0;

  logic [W-1:0] mosi_seen;
  int edges, cs_low, done_cnt, done_cyc, busy_gap, post_busy;
  int first_edge_cyc, mosi_chg_cyc;

  spi_xfer_ctrl_if #(.DATA_WIDTH(W)) bus ();

  spi_xfer_ctrl #(
    .DATA_WIDTH  (W),
    .CLOCK_RATIO (RATIO)
  ) dut (
    .clk_in    (clk_in),
    .async_rst (async_rst),
    .bus       (bus)
  );

  assign bus.miso = loopback ? bus.mosi : miso_bit;

  always #5 clk_in = ~clk_in;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Cycle 1 is the cycle right after the edge that samples start.
  task automatic run_xfer(input vec_t v, input bit disturb, input int abort_at);
    logic prev_sclk;
    logic mosi0;
    logic lead;
    int   samp;
    @(negedge clk_in);
    bus.cpol  = v.cpol;
    bus.cpha  = v.cpha;
    bus.start = 1'b0;
    loopback  = v.loopback;
    miso_bit  = v.miso_word[W-1];
    @(negedge clk_in);
    bus.tx_data = v.tx;
    bus.start   = 1'b1;
    prev_sclk   = bus.sclk;
    mosi0       = bus.mosi;
    chk("pre_start_sclk", prev_sclk, v.cpol);
    @(negedge clk_in);
    bus.start = 1'b0;
    edges = 0; cs_low = 0; done_cnt = 0; done_cyc = 0; busy_gap = 0; post_busy = 0;
    first_edge_cyc = 0; mosi_chg_cyc = 0; samp = 0; mosi_seen = '0;
    for (int cyc = 1; cyc <= 80; cyc++) begin
      if (abort_at != 0 && cyc == abort_at) begin
        async_rst = 1'b1;
        #1;
        chk("abort_cs_n", bus.cs_n, 1);
        chk("abort_sclk", bus.sclk, 0);
        chk("abort_busy", bus.busy, 0);
        chk("abort_rx_data", bus.rx_data, 0);
      end else if (abort_at != 0 && cyc == abort_at + 1) begin
        async_rst = 1'b0;
      end
      if (!bus.cs_n) cs_low++;
      if (bus.done) begin
        done_cnt++;
        if (done_cyc == 0) begin
          done_cyc = cyc;
          if (disturb) bus.start = 1'b1;
        end
      end else if (disturb && done_cyc != 0 && cyc == done_cyc + 1) begin
        bus.start = 1'b0;
      end
      if (done_cyc == 0 && !bus.busy) busy_gap++;
      if (done_cyc != 0 && cyc > done_cyc && bus.busy) post_busy++;
      if (done_cyc == 0 && bus.sclk !== prev_sclk) begin
        edges++;
        if (first_edge_cyc == 0) first_edge_cyc = cyc;
        lead = (bus.sclk != v.cpol);
        if (lead != v.cpha) begin
          mosi_seen = {mosi_seen[W-2:0], bus.mosi};
          samp++;
          if (samp < W) miso_bit = v.miso_word[W-1-samp];
        end
      end
      if (mosi_chg_cyc == 0 && bus.mosi !== mosi0) mosi_chg_cyc = cyc;
      prev_sclk = bus.sclk;
      if (disturb && cyc == 10) begin
        bus.start   = 1'b1;
        bus.tx_data = ~v.tx;
        bus.cpol    = ~v.cpol;
        bus.cpha    = ~v.cpha;
      end
      if (disturb && cyc == 11) begin
        bus.start   = 1'b0;
        bus.tx_data = v.tx;
        bus.cpol    = v.cpol;
        bus.cpha    = v.cpha;
      end
      if (done_cyc != 0 && cyc >= done_cyc + 3) break;
      @(negedge clk_in);
    end
  endtask

  initial begin
    vec_t tbl[4];
    vec_t v;

    bus.start   = 1'b0;
    bus.cpol    = 1'b0;
    bus.cpha    = 1'b0;
    bus.tx_data = '0;

    // Reset acts before any clock edge.
    #2 async_rst = 1'b1;
    #1;
    chk("rst_cs_n", bus.cs_n, 1);
    chk("rst_sclk", bus.sclk, 0);
    chk("rst_mosi", bus.mosi, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_rx_data", bus.rx_data, 0);
    @(negedge clk_in);
    async_rst = 1'b0;
    repeat (2) @(negedge clk_in);
    chk("idle_busy", bus.busy, 0);

    tbl[0] = '{cpol: 1'b0, cpha: 1'b0, tx: 8'hA5, miso_word: 8'h00, loopback: 1'b1, exp_rx: 8'hA5};
    tbl[1] = '{cpol: 1'b1, cpha: 1'b1, tx: 8'h3C, miso_word: 8'hFF, loopback: 1'b0, exp_rx: 8'hFF};
    tbl[2] = '{cpol: 1'b0, cpha: 1'b1, tx: 8'h81, miso_word: 8'h5A, loopback: 1'b0, exp_rx: 8'h5A};
    tbl[3] = '{cpol: 1'b1, cpha: 1'b0, tx: 8'hC3, miso_word: 8'h96, loopback: 1'b0, exp_rx: 8'h96};

    for (int i = 0; i < 4; i++) begin
      run_xfer(tbl[i], 1'b0, 0);
      chk($sformatf("rx_data[%0d]", i), bus.rx_data, tbl[i].exp_rx);
      chk($sformatf("mosi_bits[%0d]", i), mosi_seen, tbl[i].tx);
      chk($sformatf("sclk_edges[%0d]", i), edges, 2 * W);
      chk($sformatf("cs_low_cycles[%0d]", i), cs_low, CS_LOW);
      chk($sformatf("done_cycle[%0d]", i), done_cyc, DONE_CYC);
      chk($sformatf("done_pulses[%0d]", i), done_cnt, 1);
      chk($sformatf("busy_gap[%0d]", i), busy_gap, 0);
      chk($sformatf("busy_after_done[%0d]", i), post_busy, 0);
      chk($sformatf("idle_sclk[%0d]", i), bus.sclk, tbl[i].cpol);
    end

    // start re-pulsed mid-transfer (with new settings) and during DONE.
    v = '{cpol: 1'b0, cpha: 1'b0, tx: 8'h6E, miso_word: 8'h39, loopback: 1'b0, exp_rx: 8'h39};
    run_xfer(v, 1'b1, 0);
    chk("restart_rx_data", bus.rx_data, v.exp_rx);
    chk("restart_mosi_bits", mosi_seen, v.tx);
    chk("restart_done_cycle", done_cyc, DONE_CYC);
    chk("restart_done_pulses", done_cnt, 1);
    chk("restart_busy_gap", busy_gap, 0);
    chk("restart_busy_after_done", post_busy, 0);

    // Reset at cycle 20 of a transfer.
    v = '{cpol: 1'b0, cpha: 1'b0, tx: 8'hF0, miso_word: 8'h0F, loopback: 1'b0, exp_rx: 8'h00};
    run_xfer(v, 1'b0, 20);
    chk("abort_done_pulses", done_cnt, 0);
    chk("abort_rx_after", bus.rx_data, 0);
    chk("abort_cs_n_after", bus.cs_n, 1);

    // Fresh mode-1 transfer after the abort; mosi left at 0 by reset.
    v = '{cpol: 1'b0, cpha: 1'b1, tx: 8'h81, miso_word: 8'h5A, loopback: 1'b0, exp_rx: 8'h5A};
    run_xfer(v, 1'b0, 0);
    chk("mode1_rx_data", bus.rx_data, v.exp_rx);
    chk("mode1_mosi_bits", mosi_seen, v.tx);
    chk("mode1_done_cycle", done_cyc, DONE_CYC);
    chk("mode1_first_edge_cycle", first_edge_cyc, 2 * HALF + 1);
    chk("mode1_mosi_first_change", mosi_chg_cyc, 2 * HALF + 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/spi_xfer_ctrl.md
SPI_XFER_CTRL -- requirements
Module: spi_xfer_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 8, bits per transfer (legal 4..16).
REQ-002 Parameter CLOCK_RATIO, default from shared SPI package, clk_in cycles per SCLK period (even, >=4); HALF = CLOCK_RATIO/2.
REQ-003 clk_in  input  1  sole clock; all state updates on rising edge.
REQ-004 async_rst  input  1  reset; asynchronous, active-high.
REQ-005 start  input  1  transfer request; sampled only in IDLE.
REQ-006 cpol  input  1  SCLK idle level; latched at accepted start.
REQ-007 cpha  input  1  sample phase (0: sample leading edge, 1: sample trailing edge); latched at accepted start.
REQ-008 tx_data  input  DATA_WIDTH  word to send, MSB first; latched at accepted start.
REQ-009 miso  input  1  serial data in.
REQ-010 busy  output  1  high from the cycle after accepted start through the DONE cycle inclusive.
REQ-011 done  output  1  single-cycle pulse at transfer completion.
REQ-012 rx_data  output  DATA_WIDTH  last received word; updated only on entry to DONE.
REQ-013 sclk  output  1  registered SPI clock.
REQ-014 mosi  output  1  registered serial data out.
REQ-015 cs_n  output  1  registered chip select, active-low.

Function
REQ-016 FSM states: IDLE, SETUP, XFER, HOLD, DONE.
REQ-017 IDLE: start=1 -> SETUP next cycle; latch cpol, cpha, tx_data; cs_n<=0, busy<=1; start=0 -> stay, sclk<=cpol input each cycle.
REQ-018 Half-period timer counts 0..HALF-1, cleared on every state entry; tick when count==HALF-1.
REQ-019 SETUP lasts exactly HALF cycles, then XFER; mosi = tx_data MSB from SETUP entry if cpha=0, and from first leading edge if cpha=1.
REQ-020 XFER: each tick toggles sclk; edge counter 1..2*DATA_WIDTH; odd edges leading, even edges trailing.
REQ-021 cpha=0: sample miso into shift register on leading edges; shift next bit onto mosi on trailing edges, except the final one.
REQ-022 cpha=1: shift next bit onto mosi on leading edges; sample miso on trailing edges.
REQ-023 After edge 2*DATA_WIDTH (sclk back at latched cpol) -> HOLD; HOLD lasts HALF cycles, cs_n stays 0.
REQ-024 DONE lasts one cycle: done=1, cs_n=1, rx_data = received word (first-sampled bit at MSB); then IDLE.
REQ-025 Latency: done asserts (2*DATA_WIDTH+2)*HALF+1 cycles after the clk_in edge that samples start.
REQ-026 start while busy, including during DONE, is ignored; no queuing.
REQ-027 cpol/cpha/tx_data changes after acceptance have no effect on the transfer in progress.
REQ-028 Counters width = ceil(log2) of their maximum; no wrap occurs within a legal transfer.

Reset
REQ-029 async_rst=1 immediately forces IDLE, cs_n=1, sclk=0, mosi=0, busy=0, done=0, rx_data=0, all counters 0.
REQ-030 Reset mid-transfer aborts with no done pulse and rx_data=0; the first start after release begins a fresh transfer.

Structure
REQ-031 Shared package alpharetz_spi_pkg holds CLOCK_RATIO, the default DATA_WIDTH, and the FSM state enum typedef.
REQ-032 One sub-module, spi_half_tick, holds the half-period timer (clear input, tick output).

Verification (DATA_WIDTH=8, CLOCK_RATIO=4)
REQ-033 Mode 0, tx_data=0xA5, miso looped to mosi -> rx_data=0xA5, done 37 cycles after start, cs_n low for 36 cycles, 16 sclk edges.
REQ-034 Mode 3 (cpol=1, cpha=1), tx_data=0x3C, miso tied 1 -> sclk idles 1, mosi bits 0,0,1,1,1,1,0,0 on leading edges, rx_data=0xFF.
REQ-035 start pulsed again at cycle 10 of a transfer and during DONE -> ignored; exactly one done pulse; busy remains continuous.
REQ-036 async_rst asserted at cycle 20 of a transfer -> cs_n=1 and sclk=0 without waiting for a clock edge, no done pulse, rx_data=0.
REQ-037 Mode 1, tx_data=0x81, miso driven with 0x5A on trailing-edge samples -> rx_data=0x5A, mosi first changes at the first leading edge.
